// File: rtl/flappy_game_ctrl.sv
// Flappy game controller: state machine, physics tick divider,
// pipe scroll/reload, scoring and bird collision detection.
module flappy_game_ctrl #(
   parameter int TICK_DIV   = 2000000,
   parameter int SCREEN_W   = 640,
   parameter int FLOOR_Y    = 440,
   parameter int PIPE_W     = 60,
   parameter int PIPE_GAP   = 120,
   parameter int PIPE_SPEED = 4,
   parameter int BIRD_W     = 20,
   parameter int BIRD_H     = 20,
   parameter int GAP_MIN    = 80,
   parameter int HIT_TICKS  = 25
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Start,
   input  logic [9:0] YBird,
   input  logic [9:0] XBird,
   output logic       Tick,
   output logic       BirdRun,
   output logic [9:0] PipeX,
   output logic [9:0] GapY,
   output logic [7:0] Score,
   output logic       GameOver,
   output logic [1:0] State
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_HIT  = 2'b10,
      S_OVER = 2'b11
   } state_t;

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int HW = $clog2(HIT_TICKS + 1);

   localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
   localparam logic [HW-1:0] HIT_MAX = HW'(HIT_TICKS);
   localparam logic [10:0]   L_PW    = 11'(PIPE_W);
   localparam logic [10:0]   L_GAP   = 11'(PIPE_GAP);
   localparam logic [10:0]   L_SPD   = 11'(PIPE_SPEED);
   localparam logic [10:0]   L_BW    = 11'(BIRD_W);
   localparam logic [10:0]   L_BH    = 11'(BIRD_H);
   localparam logic [10:0]   L_FLOOR = 11'(FLOOR_Y);
   localparam logic [9:0]    L_SCR   = 10'(SCREEN_W);
   localparam logic [9:0]    L_GMIN  = 10'(GAP_MIN);
   localparam logic [9:0]    L_PSPD  = 10'(PIPE_SPEED);

   state_t          r_state;
   logic            r_start_q;
   logic [7:0]      r_lfsr;
   logic [CW-1:0]   r_cnt;
   logic [HW-1:0]   r_hit_cnt;
   logic            r_passed;
   logic            r_bird_run;
   logic            r_game_over;
   logic [9:0]      r_pipe_x;
   logic [9:0]      r_gap_y;
   logic [7:0]      r_score;

   logic            w_start_edge;
   logic            w_fb;
   logic            w_tick;
   logic [10:0]     w_px;
   logic [10:0]     w_pipe_r;
   logic [10:0]     w_bx;
   logic [10:0]     w_bird_r;
   logic [10:0]     w_by;
   logic [10:0]     w_bird_b;
   logic [10:0]     w_gy;
   logic [10:0]     w_gap_b;
   logic            w_floor;
   logic            w_hov;
   logic            w_vmiss;
   logic            w_collide;
   logic            w_offscreen;
   logic            w_score_hit;
   logic [9:0]      w_new_gap;
   logic [HW-1:0]   w_hit_next;
   logic [CW-1:0]   w_cnt_next;

   assign w_start_edge = Start & ~r_start_q;
   assign w_fb         = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
   assign w_tick       = ((r_state == S_RUN) || (r_state == S_HIT))
                         && (r_cnt == CNT_MAX);
   assign w_cnt_next   = (r_cnt == CNT_MAX) ? '0 : r_cnt + 1'b1;
   assign w_hit_next   = r_hit_cnt + 1'b1;

   assign w_px     = {1'b0, r_pipe_x};
   assign w_pipe_r = w_px + L_PW;
   assign w_bx     = {1'b0, XBird};
   assign w_bird_r = w_bx + L_BW;
   assign w_by     = {1'b0, YBird};
   assign w_bird_b = w_by + L_BH;
   assign w_gy     = {1'b0, r_gap_y};
   assign w_gap_b  = w_gy + L_GAP;

   assign w_floor   = (w_bird_b >= L_FLOOR);
   assign w_hov     = (w_bird_r > w_px) && (w_bx < w_pipe_r);
   assign w_vmiss   = (w_by < w_gy) || (w_bird_b > w_gap_b);
   assign w_collide = (r_state == S_RUN) && (w_floor || (w_hov && w_vmiss));

   // Reload also when one more step would take PipeX below zero.
   assign w_offscreen = (w_pipe_r <= L_SPD) || (w_px < L_SPD);
   assign w_score_hit = !r_passed && (w_pipe_r < w_bx);
   assign w_new_gap   = L_GMIN + {3'b000, r_lfsr[6:0]};

   assign Tick     = w_tick && (r_state == S_RUN);
   assign BirdRun  = r_bird_run;
   assign GameOver = r_game_over;
   assign PipeX    = r_pipe_x;
   assign GapY     = r_gap_y;
   assign Score    = r_score;
   assign State    = r_state;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state     <= S_IDLE;
         r_start_q   <= 1'b0;
         r_lfsr      <= 8'hA5;
         r_cnt       <= '0;
         r_hit_cnt   <= '0;
         r_passed    <= 1'b0;
         r_bird_run  <= 1'b0;
         r_game_over <= 1'b0;
         r_pipe_x    <= L_SCR;
         r_gap_y     <= L_GMIN;
         r_score     <= 8'd0;
      end else begin
         r_start_q <= Start;
         r_lfsr    <= {r_lfsr[6:0], w_fb};
         unique case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               if (w_start_edge) begin
                  r_state    <= S_RUN;
                  r_bird_run <= 1'b1;
                  r_pipe_x   <= L_SCR;
                  r_gap_y    <= w_new_gap;
                  r_score    <= 8'd0;
                  r_passed   <= 1'b0;
               end
            end
            S_RUN: begin
               if (w_collide) begin
                  r_state   <= S_HIT;
                  r_cnt     <= '0;
                  r_hit_cnt <= '0;
               end else begin
                  r_cnt <= w_cnt_next;
                  if (w_tick) begin
                     if (w_score_hit) begin
                        r_passed <= 1'b1;
                        if (r_score != 8'hFF)
                           r_score <= r_score + 8'd1;
                     end
                     if (w_offscreen) begin
                        r_pipe_x <= L_SCR;
                        r_gap_y  <= w_new_gap;
                        r_passed <= 1'b0;
                     end else begin
                        r_pipe_x <= r_pipe_x - L_PSPD;
                     end
                  end
               end
            end
            S_HIT: begin
               r_cnt <= w_cnt_next;
               if (w_tick) begin
                  r_hit_cnt <= w_hit_next;
                  if (w_hit_next == HIT_MAX) begin
                     r_state     <= S_OVER;
                     r_bird_run  <= 1'b0;
                     r_game_over <= 1'b1;
                     r_cnt       <= '0;
                  end
               end
            end
            S_OVER: begin
               r_cnt <= '0;
               if (w_start_edge) begin
                  r_state     <= S_IDLE;
                  r_game_over <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
